md_sched: RTL and testbench
===========================

Name: md_sched

Overview:
- Controller for the pipeline's multi-cycle multiply/divide resource.
- Accepts MD ops from E stage, registers the operands and launches an external arithmetic datapath.
- Counts the per-op latency, then commits the datapath's HI/LO results into the architectural HI/LO registers it owns.
- Drives busy/stall for D-stage hazard control; honours the exception cancel window.

Parameters:
- WIDTH, 32, data width of rs/rt/HI/LO.
- MUL_LAT, 5, RUN cycles for MULT/MULTU (legal range 1..15).
- DIV_LAT, 10, RUN cycles for DIV/DIVU (legal range 1..15).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low.
- op_valid  input  1  E-stage MD op present this cycle.
- op  input  3  1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 0/7 no-op.
- rs  input  WIDTH  operand A / MTHI/MTLO data.
- rt  input  WIDTH  operand B.
- cancel  input  1  exception flush (kills the E op and the op issued last cycle).
- d_md_use  input  1  D-stage instruction is an MD op or MFHI/MFLO.
- dp_start  output  1  registered pulse in the first RUN cycle.
- dp_op  output  2  0 mult, 1 multu, 2 div, 3 divu; held through RUN.
- dp_a  output  WIDTH  registered rs; held through RUN.
- dp_b  output  WIDTH  registered rt; held through RUN.
- dp_hi  input  WIDTH  datapath result HI; must be valid in the last RUN cycle.
- dp_lo  input  WIDTH  datapath result LO; must be valid in the last RUN cycle.
- hi  output  WIDTH  architectural HI.
- lo  output  WIDTH  architectural LO.
- busy  output  1  combinational: (state==RUN) | issue.
- stall  output  1  combinational: d_md_use & busy.
- proto_err  output  1  sticky: op_valid with a legal op arrived while state==RUN.

Behaviour:
- Reset (async, reset low), all registers cleared:
  - state=IDLE; cnt=0; hi=lo=0; backups=0.
  - dp_start=0, dp_op=0, dp_a=dp_b=0; just_issued=0; proto_err=0.
- issue = op_valid & legal op & ~cancel & state==IDLE.
- IDLE, on an issue edge:
  - MULT/MULTU/DIV/DIVU:
    - Capture dp_a<=rs, dp_b<=rt, dp_op.
    - cnt<=MUL_LAT or DIV_LAT; state<=RUN; dp_start<=1.
    - Backups hi_bak<=hi, lo_bak<=lo.
  - MTHI: hi<=rs, hi_bak<=old hi; state stays IDLE; no busy after the issue cycle.
  - MTLO: lo<=rs, lo_bak<=old lo; same as MTHI otherwise.
  - All legal ops: just_issued<=1. Otherwise just_issued<=0.
- RUN:
  - dp_start is 1 only in the first RUN cycle.
  - cnt decrements each edge.
  - At the edge ending the cycle with cnt==1: hi<=dp_hi, lo<=dp_lo, state<=IDLE.
  - busy is therefore high in the issue cycle plus exactly LAT cycles after it.
- Cancel window:
  - cancel with just_issued=1 aborts the op issued last cycle: state<=IDLE, cnt<=0, hi<=hi_bak, lo<=lo_bak, no commit.
  - This also covers LAT=1, where cancel and the commit edge coincide: cancel wins.
  - cancel with just_issued=0 does not affect a running op or HI/LO.
  - cancel together with op_valid in the same cycle: the op is not issued.
- op_valid during RUN: ignored (no state change, operands not recaptured); proto_err<=1 until reset.
- Back-to-back: an op may issue in the cycle immediately after the commit edge.
- Reset mid-RUN: immediate abort; hi/lo=0; no commit.
- Datapath results, including divide-by-zero, are committed as-is with no checking.

Test Plan:
- Reset release, MULT rs=0xFFFFFFFE rt=3 with dp model: busy high 6 cycles, dp_start pulses once, stall follows d_md_use; hi=0xFFFFFFFF, lo=0xFFFFFFFA after commit.
- DIVU rs=100 rt=7: busy 11 cycles; hi=2, lo=14; a second DIVU issued the cycle after commit is accepted.
- MTHI 0x1234 then cancel next cycle: hi returns to the prior value 0xABCD; busy never set beyond the issue cycle.
- DIV issue, cancel next cycle: state IDLE, hi/lo unchanged, dp_start seen once; cancel on the 3rd RUN cycle: no effect, result commits.
- op_valid MULT during RUN: ignored, proto_err=1 and sticky; cancel+op_valid same cycle: no issue, busy=0.
- Reset driven low mid-RUN of MULT: hi=lo=0, busy=0 asynchronously; no commit after release.

Source files
------------

// File: rtl/md_sched.sv
// md_sched: multi-cycle multiply/divide scheduler owning the architectural HI/LO registers
//   in : clk, reset (async, active-low), op_valid, op, rs, rt, cancel, d_md_use, dp_hi, dp_lo
//   out: dp_start, dp_op, dp_a, dp_b (datapath launch), hi, lo, busy, stall, proto_err
module md_sched #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             cancel,
  input  logic             d_md_use,
  output logic             dp_start,
  output logic [1:0]       dp_op,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  input  logic [WIDTH-1:0] dp_hi,
  input  logic [WIDTH-1:0] dp_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             proto_err
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, hi_bak_q, hi_bak_d, lo_bak_q, lo_bak_d;
  logic [WIDTH-1:0] dp_a_q, dp_a_d, dp_b_q, dp_b_d;
  logic [1:0] dp_op_q, dp_op_d;
  logic dp_start_q, dp_start_d, just_issued_q, just_issued_d, proto_err_q, proto_err_d;
  logic legal, arith, is_div, issue, abort;
  always_comb begin
    legal = (op != 3'd0) && (op != 3'd7);
    arith = op <= 3'd4;
    is_div = (op == 3'd3) || (op == 3'd4);
    issue = op_valid & legal & ~cancel & (state_q == IDLE);
    abort = cancel & just_issued_q;
    state_d = state_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    hi_bak_d = hi_bak_q;
    lo_bak_d = lo_bak_q;
    dp_a_d = dp_a_q;
    dp_b_d = dp_b_q;
    dp_op_d = dp_op_q;
    dp_start_d = 1'b0;
    just_issued_d = issue;
    proto_err_d = proto_err_q | (op_valid & legal & (state_q == RUN));
    // the abort test comes first so that with a 1-cycle latency the cancel beats the commit
    if (abort) begin
      state_d = IDLE;
      cnt_d = '0;
      hi_d = hi_bak_q;
      lo_d = lo_bak_q;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        hi_d = dp_hi;
        lo_d = dp_lo;
        state_d = IDLE;
      end
    end else if (issue) begin
      // both halves are snapshotted so a cancelled MTHI/MTLO never restores a stale value
      hi_bak_d = hi_q;
      lo_bak_d = lo_q;
      if (arith) begin
        dp_a_d = rs;
        dp_b_d = rt;
        dp_op_d = op[1:0] - 2'd1;
        cnt_d = is_div ? DIV_CNT : MUL_CNT;
        state_d = RUN;
        dp_start_d = 1'b1;
      end else begin
        hi_d = (op == 3'd5) ? rs : hi_q;
        lo_d = (op == 3'd6) ? rs : lo_q;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      hi_bak_q <= '0;
      lo_bak_q <= '0;
      dp_a_q <= '0;
      dp_b_q <= '0;
      dp_op_q <= '0;
      dp_start_q <= 1'b0;
      just_issued_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      hi_bak_q <= hi_bak_d;
      lo_bak_q <= lo_bak_d;
      dp_a_q <= dp_a_d;
      dp_b_q <= dp_b_d;
      dp_op_q <= dp_op_d;
      dp_start_q <= dp_start_d;
      just_issued_q <= just_issued_d;
      proto_err_q <= proto_err_d;
    end
  end
  assign dp_start = dp_start_q;
  assign dp_op = dp_op_q;
  assign dp_a = dp_a_q;
  assign dp_b = dp_b_q;
  assign hi = hi_q;
  assign lo = lo_q;
  assign busy = (state_q == RUN) | issue;
  assign stall = d_md_use & busy;
  assign proto_err = proto_err_q;
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: table, directed and random checks of md_sched at latencies 5/10 and 1/1
module tb_md_sched;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  logic op_valid = 1'b0, cancel = 1'b0, d_md_use = 1'b0;
  logic [2:0] op = 3'd0;
  logic [W-1:0] rs = '0, rt = '0;
  logic [W-1:0] dph [2], dpl [2], a_w [2], b_w [2], hi_w [2], lo_w [2];
  logic [1:0] op_w [2];
  logic start_w [2], busy_w [2], stall_w [2], perr_w [2];
  md_sched #(.WIDTH(W), .MUL_LAT(5), .DIV_LAT(10)) dut0 (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .rs(rs), .rt(rt),
    .cancel(cancel), .d_md_use(d_md_use), .dp_start(start_w[0]), .dp_op(op_w[0]),
    .dp_a(a_w[0]), .dp_b(b_w[0]), .dp_hi(dph[0]), .dp_lo(dpl[0]), .hi(hi_w[0]),
    .lo(lo_w[0]), .busy(busy_w[0]), .stall(stall_w[0]), .proto_err(perr_w[0])
  );
  md_sched #(.WIDTH(W), .MUL_LAT(1), .DIV_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .rs(rs), .rt(rt),
    .cancel(cancel), .d_md_use(d_md_use), .dp_start(start_w[1]), .dp_op(op_w[1]),
    .dp_a(a_w[1]), .dp_b(b_w[1]), .dp_hi(dph[1]), .dp_lo(dpl[1]), .hi(hi_w[1]),
    .lo(lo_w[1]), .busy(busy_w[1]), .stall(stall_w[1]), .proto_err(perr_w[1])
  );
  // returns {hi, lo}; divide by zero yields hi=a, lo=all ones
  function automatic logic [63:0] md_ref(input logic [1:0] k, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (k[1] && b == 32'd0) return {a, 32'hFFFF_FFFF};
    case (k)
      2'd0: p = 64'(sa * sb);
      2'd1: p = {32'd0, a} * {32'd0, b};
      2'd2: begin
        q = sa / sb;
        r = sa % sb;
        p = {r[31:0], q[31:0]};
      end
      default: p = {a % b, a / b};
    endcase
    return p;
  endfunction
  assign {dph[0], dpl[0]} = md_ref(op_w[0], a_w[0], b_w[0]);
  assign {dph[1], dpl[1]} = md_ref(op_w[1], a_w[1], b_w[1]);
  function automatic int lat_of(input int j, input logic [2:0] o);
    return (j == 1) ? 1 : ((o >= 3'd3) ? 10 : 5);
  endfunction
  int m_left [2];
  logic [31:0] m_hi [2], m_lo [2], s_hi [2], s_lo [2], m_a [2], m_b [2];
  logic [63:0] m_pend [2];
  logic [1:0] m_k [2];
  logic m_last [2], m_perr [2], m_start [2];
  int npass = 0, ntot = 0, busy_seen = 0, start_seen = 0;
  typedef struct { logic v; logic [2:0] o; logic c; logic u; logic eb; logic es; } vec_t;
  vec_t tbl [8];
  task automatic chk(input string n, input int j, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s[%0d]: got %0h expected %0h", n, j, act, exp);
  endtask
  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      m_left[j] = 0;
      m_hi[j] = '0;
      m_lo[j] = '0;
      s_hi[j] = '0;
      s_lo[j] = '0;
      m_a[j] = '0;
      m_b[j] = '0;
      m_pend[j] = '0;
      m_k[j] = '0;
      m_last[j] = 1'b0;
      m_perr[j] = 1'b0;
      m_start[j] = 1'b0;
    end
  endtask
  task automatic step(input logic v, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic c, input logic u);
    logic lg;
    logic mi [2];
    op_valid = v;
    op = o;
    rs = a;
    rt = b;
    cancel = c;
    d_md_use = u;
    lg = (o != 3'd0) && (o != 3'd7);
    #1;
    for (int j = 0; j < 2; j++) begin
      mi[j] = v & lg & ~c & (m_left[j] == 0);
      chk("busy", j, 64'(busy_w[j]), 64'((m_left[j] > 0) | mi[j]));
      chk("stall", j, 64'(stall_w[j]), 64'(u & ((m_left[j] > 0) | mi[j])));
    end
    if (busy_w[0]) busy_seen++;
    @(posedge clk);
    #1;
    for (int j = 0; j < 2; j++) begin
      if (v & lg & (m_left[j] > 0)) m_perr[j] = 1'b1;
      m_start[j] = 1'b0;
      if (c & m_last[j]) begin
        m_left[j] = 0;
        m_hi[j] = s_hi[j];
        m_lo[j] = s_lo[j];
      end else if (m_left[j] > 0) begin
        m_left[j]--;
        if (m_left[j] == 0) {m_hi[j], m_lo[j]} = m_pend[j];
      end else if (mi[j]) begin
        s_hi[j] = m_hi[j];
        s_lo[j] = m_lo[j];
        if (o <= 3'd4) begin
          m_k[j] = 2'(o - 3'd1);
          m_a[j] = a;
          m_b[j] = b;
          m_left[j] = lat_of(j, o);
          m_pend[j] = md_ref(m_k[j], a, b);
          m_start[j] = 1'b1;
        end else if (o == 3'd5) m_hi[j] = a;
        else m_lo[j] = a;
      end
      m_last[j] = mi[j];
      chk("hi", j, 64'(hi_w[j]), 64'(m_hi[j]));
      chk("lo", j, 64'(lo_w[j]), 64'(m_lo[j]));
      chk("proto_err", j, 64'(perr_w[j]), 64'(m_perr[j]));
      chk("dp_start", j, 64'(start_w[j]), 64'(m_start[j]));
      chk("dp_a", j, 64'(a_w[j]), 64'(m_a[j]));
      chk("dp_b", j, 64'(b_w[j]), 64'(m_b[j]));
      chk("dp_op", j, 64'(op_w[j]), 64'(m_k[j]));
    end
    if (start_w[0]) start_seen++;
  endtask
  task automatic idle(input int n);
    repeat (n) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
  endtask
  initial begin
    #500000;
    $display("FAIL timeout: run did not finish");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 3'd6, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0};
    model_reset();
    #2;
    for (int j = 0; j < 2; j++) begin
      chk("rst_hi", j, 64'(hi_w[j]), 64'd0);
      chk("rst_lo", j, 64'(lo_w[j]), 64'd0);
      chk("rst_start", j, 64'(start_w[j]), 64'd0);
      chk("rst_dp_a", j, 64'(a_w[j]), 64'd0);
      chk("rst_dp_op", j, 64'(op_w[j]), 64'd0);
      chk("rst_perr", j, 64'(perr_w[j]), 64'd0);
      chk("rst_busy", j, 64'(busy_w[j]), 64'd0);
    end
    // held in reset, so the state is IDLE and only the combinational issue path is exercised
    foreach (tbl[i]) begin
      op_valid = tbl[i].v;
      op = tbl[i].o;
      cancel = tbl[i].c;
      d_md_use = tbl[i].u;
      #1;
      for (int j = 0; j < 2; j++) begin
        chk("tbl_busy", j, 64'(busy_w[j]), 64'(tbl[i].eb));
        chk("tbl_stall", j, 64'(stall_w[j]), 64'(tbl[i].es));
      end
    end
    op_valid = 1'b0;
    op = 3'd0;
    cancel = 1'b0;
    d_md_use = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    busy_seen = 0;
    start_seen = 0;
    step(1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b1);
    idle(6);
    chk("mult_busy_cycles", 0, 64'(busy_seen), 64'd6);
    chk("mult_starts", 0, 64'(start_seen), 64'd1);
    chk("mult_hi", 0, 64'(hi_w[0]), 64'hFFFF_FFFF);
    chk("mult_lo", 0, 64'(lo_w[0]), 64'hFFFF_FFFA);
    busy_seen = 0;
    step(1'b1, 3'd4, 32'd100, 32'd7, 1'b0, 1'b0);
    idle(10);
    chk("divu_busy_cycles", 0, 64'(busy_seen), 64'd11);
    chk("divu_hi", 0, 64'(hi_w[0]), 64'd2);
    chk("divu_lo", 0, 64'(lo_w[0]), 64'd14);
    step(1'b1, 3'd4, 32'd50, 32'd8, 1'b0, 1'b0);
    idle(10);
    chk("divu2_hi", 0, 64'(hi_w[0]), 64'd2);
    chk("divu2_lo", 0, 64'(lo_w[0]), 64'd6);
    step(1'b1, 3'd5, 32'hABCD, 32'd0, 1'b0, 1'b0);
    idle(1);
    busy_seen = 0;
    step(1'b1, 3'd5, 32'h1234, 32'd0, 1'b0, 1'b1);
    chk("mthi_hi", 0, 64'(hi_w[0]), 64'h1234);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    chk("mthi_cancel_hi", 0, 64'(hi_w[0]), 64'hABCD);
    idle(2);
    chk("mthi_busy_cycles", 0, 64'(busy_seen), 64'd1);
    start_seen = 0;
    step(1'b1, 3'd3, 32'hFFFF_FFEC, 32'd3, 1'b0, 1'b0);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    idle(3);
    for (int j = 0; j < 2; j++) begin
      chk("div_cancel_hi", j, 64'(hi_w[j]), 64'hABCD);
      chk("div_cancel_lo", j, 64'(lo_w[j]), 64'd6);
    end
    chk("div_cancel_starts", 0, 64'(start_seen), 64'd1);
    step(1'b1, 3'd3, 32'hFFFF_FFEC, 32'd3, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    idle(7);
    chk("div_late_cancel_hi", 0, 64'(hi_w[0]), 64'hFFFF_FFFE);
    chk("div_late_cancel_lo", 0, 64'(lo_w[0]), 64'hFFFF_FFFA);
    step(1'b1, 3'd1, 32'd7, 32'd9, 1'b0, 1'b0);
    step(1'b1, 3'd1, 32'h55, 32'h66, 1'b0, 1'b1);
    chk("run_op_perr", 0, 64'(perr_w[0]), 64'd1);
    idle(5);
    chk("run_op_lo", 0, 64'(lo_w[0]), 64'd63);
    chk("run_op_hi", 0, 64'(hi_w[0]), 64'd0);
    chk("perr_sticky", 0, 64'(perr_w[0]), 64'd1);
    start_seen = 0;
    step(1'b1, 3'd1, 32'd3, 32'd3, 1'b1, 1'b1);
    idle(1);
    chk("cancel_valid_starts", 0, 64'(start_seen), 64'd0);
    step(1'b1, 3'd1, 32'h10, 32'h20, 1'b0, 1'b0);
    idle(2);
    reset = 1'b0;
    #1;
    for (int j = 0; j < 2; j++) begin
      chk("async_rst_hi", j, 64'(hi_w[j]), 64'd0);
      chk("async_rst_lo", j, 64'(lo_w[j]), 64'd0);
      chk("async_rst_busy", j, 64'(busy_w[j]), 64'd0);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    idle(8);
    chk("no_commit_lo", 0, 64'(lo_w[0]), 64'd0);
    repeat (2000) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, b,
           $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
